// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: load-use stall, branch flush and freeze control for the 5-stage MIPS pipeline.
// Define HAZARD_STATS_EN to add saturating load-stall and flush counters.
module id_ex_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [4:0] i_ID_data_RSAddr,
    input  logic [4:0] i_ID_data_RTAddr,
    input  logic       i_ID_ctrl_UsesRT,
    input  logic       i_EX_ctrl_MemRead,
    input  logic [4:0] i_EX_data_RTAddr,
    input  logic       i_MEM_ctrl_BranchTaken,
    input  logic       i_ext_stall,
    output logic       o_IF_ctrl_PCWrite,
    output logic       o_IFID_ctrl_Write,
    output logic       o_IFID_ctrl_Flush,
    output logic       o_IDEX_ctrl_Bubble,
    output logic       o_IDEX_ctrl_Hold,
    output logic       o_EXMEM_ctrl_Flush,
    output logic       o_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] o_stat_LoadStalls,
    output logic [CNT_WIDTH-1:0] o_stat_Flushes
`endif
);
    typedef enum logic {RUN, LDSTALL} state_t;

    state_t     r_state, w_next_state;
    logic [3:0] r_cnt, w_next_cnt;
    logic       w_haz, w_pcw, w_ifidw, w_ifidf, w_bub, w_hold, w_exf;

    assign w_haz = i_EX_ctrl_MemRead & (i_EX_data_RTAddr != 5'd0) &
                   ((i_EX_data_RTAddr == i_ID_data_RSAddr) |
                    (i_ID_ctrl_UsesRT & (i_EX_data_RTAddr == i_ID_data_RTAddr)));

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_pcw        = 1'b1;
        w_ifidw      = 1'b1;
        w_ifidf      = 1'b0;
        w_bub        = 1'b0;
        w_hold       = 1'b0;
        w_exf        = 1'b0;
        if (i_MEM_ctrl_BranchTaken) begin
            w_ifidf      = 1'b1;
            w_bub        = 1'b1;
            w_exf        = 1'b1;
            w_next_state = RUN;
            w_next_cnt   = 4'd0;
        end else if (i_ext_stall) begin
            w_pcw   = 1'b0;
            w_ifidw = 1'b0;
            w_hold  = 1'b1;
        end else if (r_state == RUN && w_haz) begin
            w_pcw   = 1'b0;
            w_ifidw = 1'b0;
            w_bub   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                w_next_state = LDSTALL;
                w_next_cnt   = 4'(LOAD_STALL_CYCLES - 1);
            end
        end else if (r_state == LDSTALL) begin
            w_pcw        = 1'b0;
            w_ifidw      = 1'b0;
            w_bub        = 1'b1;
            w_next_cnt   = r_cnt - 4'd1;
            w_next_state = (r_cnt == 4'd1) ? RUN : LDSTALL;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Reset overrides the decode so the pipeline sits in a bubbling, frozen state.
    assign o_IF_ctrl_PCWrite  = nrst & w_pcw;
    assign o_IFID_ctrl_Write  = nrst & w_ifidw;
    assign o_IFID_ctrl_Flush  = nrst & w_ifidf;
    assign o_IDEX_ctrl_Bubble = ~nrst | w_bub;
    assign o_IDEX_ctrl_Hold   = nrst & w_hold;
    assign o_EXMEM_ctrl_Flush = nrst & w_exf;
    assign o_busy             = (r_state == LDSTALL);

`ifdef HAZARD_STATS_EN
    logic [CNT_WIDTH-1:0] r_ls, r_fl;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ls <= '0;
            r_fl <= '0;
        end else begin
            if (w_bub && !i_MEM_ctrl_BranchTaken && r_ls != '1) r_ls <= r_ls + 1'b1;
            if (i_MEM_ctrl_BranchTaken && r_fl != '1) r_fl <= r_fl + 1'b1;
        end
    end

    assign o_stat_LoadStalls = r_ls;
    assign o_stat_Flushes    = r_fl;
`endif
endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// tb_id_ex_hazard_ctrl: directed checks of a default instance (1 bubble) and a 3-bubble instance.
module tb_id_ex_hazard_ctrl;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [4:0] rs = 5'd0, rt = 5'd0, ex_rt = 5'd0;
    logic       uses_rt = 1'b0, memrd = 1'b0, br = 1'b0, ext = 1'b0;
    logic       a_pcw, a_ifw, a_iff, a_bub, a_hold, a_exf, a_busy;
    logic       b_pcw, b_ifw, b_iff, b_bub, b_hold, b_exf, b_busy;
`ifdef HAZARD_STATS_EN
    logic [15:0] a_ls, a_fl, b_ls, b_fl;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_hazard_ctrl u_dut1 (
        .clk(clk), .nrst(nrst),
        .i_ID_data_RSAddr(rs), .i_ID_data_RTAddr(rt), .i_ID_ctrl_UsesRT(uses_rt),
        .i_EX_ctrl_MemRead(memrd), .i_EX_data_RTAddr(ex_rt),
        .i_MEM_ctrl_BranchTaken(br), .i_ext_stall(ext),
        .o_IF_ctrl_PCWrite(a_pcw), .o_IFID_ctrl_Write(a_ifw), .o_IFID_ctrl_Flush(a_iff),
        .o_IDEX_ctrl_Bubble(a_bub), .o_IDEX_ctrl_Hold(a_hold), .o_EXMEM_ctrl_Flush(a_exf),
        .o_busy(a_busy)
`ifdef HAZARD_STATS_EN
        , .o_stat_LoadStalls(a_ls), .o_stat_Flushes(a_fl)
`endif
    );

    id_ex_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u_dut3 (
        .clk(clk), .nrst(nrst),
        .i_ID_data_RSAddr(rs), .i_ID_data_RTAddr(rt), .i_ID_ctrl_UsesRT(uses_rt),
        .i_EX_ctrl_MemRead(memrd), .i_EX_data_RTAddr(ex_rt),
        .i_MEM_ctrl_BranchTaken(br), .i_ext_stall(ext),
        .o_IF_ctrl_PCWrite(b_pcw), .o_IFID_ctrl_Write(b_ifw), .o_IFID_ctrl_Flush(b_iff),
        .o_IDEX_ctrl_Bubble(b_bub), .o_IDEX_ctrl_Hold(b_hold), .o_EXMEM_ctrl_Flush(b_exf),
        .o_busy(b_busy)
`ifdef HAZARD_STATS_EN
        , .o_stat_LoadStalls(b_ls), .o_stat_Flushes(b_fl)
`endif
    );

    task automatic idle(input int n);
        rs = 0; rt = 0; ex_rt = 0; uses_rt = 0; memrd = 0; br = 0; ext = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 0;
        repeat (3) begin
            @(negedge clk); #1;
            checks++; if (a_pcw !== 1'b0) begin errors++; $display("FAIL rst_pcw got=%b exp=0", a_pcw); end
            checks++; if (a_ifw !== 1'b0) begin errors++; $display("FAIL rst_ifw got=%b exp=0", a_ifw); end
            checks++; if (a_bub !== 1'b1) begin errors++; $display("FAIL rst_bub got=%b exp=1", a_bub); end
            checks++; if ({a_iff, a_hold, a_exf, a_busy} !== 4'b0) begin errors++; $display("FAIL rst_misc got=%b exp=0000", {a_iff, a_hold, a_exf, a_busy}); end
        end
        @(negedge clk); nrst = 1; #1;
        checks++; if ({a_pcw, a_ifw, a_bub} !== 3'b110) begin errors++; $display("FAIL rel_run got=%b exp=110", {a_pcw, a_ifw, a_bub}); end
        checks++; if ({b_pcw, b_ifw, b_bub, b_busy} !== 4'b1100) begin errors++; $display("FAIL rel_run3 got=%b exp=1100", {b_pcw, b_ifw, b_bub, b_busy}); end
    endtask

    task automatic test_load_use();
        @(negedge clk); memrd = 1; ex_rt = 5; rs = 5; #1;
        checks++; if ({a_pcw, a_ifw, a_bub} !== 3'b001) begin errors++; $display("FAIL lu_stall got=%b exp=001", {a_pcw, a_ifw, a_bub}); end
        @(negedge clk); memrd = 0; #1;
        checks++; if ({a_pcw, a_ifw, a_bub, a_busy} !== 4'b1100) begin errors++; $display("FAIL lu_after got=%b exp=1100", {a_pcw, a_ifw, a_bub, a_busy}); end
        idle(3);
    endtask

    task automatic test_no_stall();
        @(negedge clk); memrd = 1; ex_rt = 0; rs = 0; #1;
        checks++; if ({a_pcw, a_bub, b_pcw, b_bub} !== 4'b1010) begin errors++; $display("FAIL r0_nostall got=%b exp=1010", {a_pcw, a_bub, b_pcw, b_bub}); end
        @(negedge clk); ex_rt = 7; rt = 7; rs = 3; uses_rt = 0; #1;
        checks++; if ({a_pcw, a_bub, b_pcw, b_bub} !== 4'b1010) begin errors++; $display("FAIL rt_unused got=%b exp=1010", {a_pcw, a_bub, b_pcw, b_bub}); end
        @(negedge clk); memrd = 0; uses_rt = 1; #1;
        checks++; if ({a_pcw, a_bub} !== 2'b10) begin errors++; $display("FAIL no_memrd got=%b exp=10", {a_pcw, a_bub}); end
        @(negedge clk); memrd = 1; #1;
        checks++; if ({a_pcw, a_bub} !== 2'b01) begin errors++; $display("FAIL rt_used got=%b exp=01", {a_pcw, a_bub}); end
        idle(4);
    endtask

    task automatic test_multi_stall();
        @(negedge clk); memrd = 1; ex_rt = 9; rs = 9; #1;
        checks++; if ({b_pcw, b_bub, b_busy} !== 3'b010) begin errors++; $display("FAIL l3_c1 got=%b exp=010", {b_pcw, b_bub, b_busy}); end
        @(negedge clk); memrd = 0; #1;
        checks++; if ({b_pcw, b_ifw, b_bub, b_busy} !== 4'b0011) begin errors++; $display("FAIL l3_c2 got=%b exp=0011", {b_pcw, b_ifw, b_bub, b_busy}); end
        checks++; if ({a_pcw, a_bub} !== 2'b10) begin errors++; $display("FAIL l1_c2 got=%b exp=10", {a_pcw, a_bub}); end
        @(negedge clk); #1;
        checks++; if ({b_pcw, b_bub, b_busy} !== 3'b011) begin errors++; $display("FAIL l3_c3 got=%b exp=011", {b_pcw, b_bub, b_busy}); end
        @(negedge clk); #1;
        checks++; if ({b_pcw, b_ifw, b_bub, b_busy} !== 4'b1100) begin errors++; $display("FAIL l3_c4 got=%b exp=1100", {b_pcw, b_ifw, b_bub, b_busy}); end
        idle(2);
    endtask

    task automatic test_branch_abort();
        @(negedge clk); memrd = 1; ex_rt = 4; rs = 4; #1;
        @(negedge clk); memrd = 0; br = 1; #1;
        checks++; if ({b_pcw, b_ifw, b_iff, b_bub, b_exf, b_hold} !== 6'b111110) begin errors++; $display("FAIL br_flush got=%b exp=111110", {b_pcw, b_ifw, b_iff, b_bub, b_exf, b_hold}); end
        checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL br_busy got=%b exp=1", b_busy); end
        @(negedge clk); br = 0; #1;
        checks++; if ({b_pcw, b_iff, b_bub, b_exf, b_busy} !== 5'b10000) begin errors++; $display("FAIL br_after got=%b exp=10000", {b_pcw, b_iff, b_bub, b_exf, b_busy}); end
        @(negedge clk); br = 1; ext = 1; #1;
        checks++; if ({a_pcw, a_hold, a_iff, a_exf} !== 4'b1011) begin errors++; $display("FAIL br_over_ext got=%b exp=1011", {a_pcw, a_hold, a_iff, a_exf}); end
        idle(2);
    endtask

    task automatic test_ext_stall();
        @(negedge clk); nrst = 0;
        @(negedge clk); nrst = 1;
        @(negedge clk); memrd = 1; ex_rt = 6; rs = 6; #1;
        checks++; if (b_bub !== 1'b1) begin errors++; $display("FAIL ext_c1 got=%b exp=1", b_bub); end
        @(negedge clk); memrd = 0; ext = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({b_pcw, b_ifw, b_hold, b_bub, b_iff, b_exf, b_busy} !== 7'b0010001) begin errors++; $display("FAIL ext_freeze%0d got=%b exp=0010001", i, {b_pcw, b_ifw, b_hold, b_bub, b_iff, b_exf, b_busy}); end
            @(negedge clk);
        end
        ext = 0; #1;
        checks++; if ({b_pcw, b_hold, b_bub, b_busy} !== 4'b0011) begin errors++; $display("FAIL ext_rem1 got=%b exp=0011", {b_pcw, b_hold, b_bub, b_busy}); end
        @(negedge clk); #1;
        checks++; if ({b_pcw, b_bub, b_busy} !== 3'b011) begin errors++; $display("FAIL ext_rem2 got=%b exp=011", {b_pcw, b_bub, b_busy}); end
        @(negedge clk); #1;
        checks++; if ({b_pcw, b_bub, b_busy} !== 3'b100) begin errors++; $display("FAIL ext_done got=%b exp=100", {b_pcw, b_bub, b_busy}); end
`ifdef HAZARD_STATS_EN
        checks++; if (b_ls !== 16'd3) begin errors++; $display("FAIL stat_ls3 got=%0d exp=3", b_ls); end
        checks++; if (a_ls !== 16'd1) begin errors++; $display("FAIL stat_ls1 got=%0d exp=1", a_ls); end
        checks++; if (b_fl !== 16'd0) begin errors++; $display("FAIL stat_fl got=%0d exp=0", b_fl); end
`endif
        idle(1);
    endtask

    task automatic test_async_reset();
        @(negedge clk); memrd = 1; ex_rt = 8; rs = 8;
        @(negedge clk); memrd = 0; #1;
        checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL ar_busy got=%b exp=1", b_busy); end
        #2 nrst = 0; #1;
        checks++; if ({b_pcw, b_ifw, b_bub, b_busy} !== 4'b0010) begin errors++; $display("FAIL ar_reset got=%b exp=0010", {b_pcw, b_ifw, b_bub, b_busy}); end
        @(negedge clk); nrst = 1; #1;
        checks++; if ({b_pcw, b_ifw, b_bub, b_busy} !== 4'b1100) begin errors++; $display("FAIL ar_release got=%b exp=1100", {b_pcw, b_ifw, b_bub, b_busy}); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_multi_stall();
        test_branch_abort();
        test_ext_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
